// File: rtl/icache_refill_router.sv
// icache_refill_router: routes instruction-cache line refills to the bootrom
// (multi-beat, assembled into one line) or to L2 (single line), and returns
// exactly one registered response per accepted request, with a timeout error.
module icache_refill_router #(
  parameter int LINE_SIZE      = 256,
  parameter int ADDR_W         = 26,
  parameter int BROM_DATA_W    = 128,
  parameter int BROM_ADDR_W    = 24,
  parameter int BROM_BASE_LINE = 0,
  parameter int BROM_LINES     = 64,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ic_req_valid_i,
  input  logic [ADDR_W-1:0]      ic_req_addr_i,
  output logic                   ic_resp_valid_o,
  output logic [LINE_SIZE-1:0]   ic_resp_data_o,
  output logic                   ic_resp_error_o,
  output logic                   busy_o,
  output logic                   brom_req_valid_o,
  output logic [BROM_ADDR_W-1:0] brom_req_address_o,
  input  logic                   brom_resp_valid_i,
  input  logic [BROM_DATA_W-1:0] brom_resp_data_i,
  output logic                   l2_req_valid_o,
  output logic [ADDR_W-1:0]      l2_req_addr_o,
  input  logic                   l2_resp_valid_i,
  input  logic [LINE_SIZE-1:0]   l2_resp_data_i
);

  localparam int NBEATS = LINE_SIZE / BROM_DATA_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int TMO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYC > 0);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEATS - 1);
  localparam logic [63:0] LINE_BYTES = 64'(LINE_SIZE / 8);
  localparam logic [63:0] BEAT_BYTES = 64'(BROM_DATA_W / 8);
  localparam logic [63:0] BROM_LO    = 64'(BROM_BASE_LINE);
  localparam logic [63:0] BROM_HI    = 64'(BROM_BASE_LINE) + 64'(BROM_LINES);

  typedef enum logic [2:0] {
    IDLE, BROM_REQ, BROM_WAIT, L2_REQ, L2_WAIT, RESP
  } state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_W-1:0]      addr_reg, addr_next;
  logic [BEAT_W-1:0]      beat_reg, beat_next;
  logic [TMO_W-1:0]       tmo_reg, tmo_next;
  logic [LINE_SIZE-1:0]   buf_reg, buf_next;
  logic                   err_reg, err_next;

  logic                   resp_valid_next;
  logic [LINE_SIZE-1:0]   resp_data_next;
  logic                   resp_error_next;
  logic                   busy_next;
  logic                   brom_req_valid_next;
  logic [BROM_ADDR_W-1:0] brom_req_addr_next;
  logic                   l2_req_valid_next;
  logic [ADDR_W-1:0]      l2_req_addr_next;

  logic [63:0] req_addr_wide;
  logic [63:0] brom_byte_addr;
  logic        in_brom;
  logic        tmo_expired;

  // Region decode and timeout expiry; the +1 form keeps the lower bound
  // check free of wrap and meaningful when the base is zero.
  always_comb begin
    req_addr_wide = 64'(ic_req_addr_i);
    in_brom       = (req_addr_wide + 64'd1 > BROM_LO) && (req_addr_wide < BROM_HI);
    tmo_expired   = TMO_EN && (tmo_reg == TMO_LAST);
  end

  // Next-state logic plus next values of every registered output, so each
  // output is valid in the same cycle its state is.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    beat_next  = beat_reg;
    tmo_next   = tmo_reg;
    buf_next   = buf_reg;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        if (ic_req_valid_i) begin
          addr_next  = ic_req_addr_i;
          beat_next  = '0;
          err_next   = 1'b0;
          state_next = in_brom ? BROM_REQ : L2_REQ;
        end
      end
      BROM_REQ: begin
        tmo_next   = '0;
        state_next = BROM_WAIT;
      end
      BROM_WAIT: begin
        if (brom_resp_valid_i) begin
          buf_next[int'(beat_reg) * BROM_DATA_W +: BROM_DATA_W] = brom_resp_data_i;
          if (beat_reg == BEAT_LAST) begin
            state_next = RESP;
          end else begin
            beat_next  = beat_reg + 1'b1;
            state_next = BROM_REQ;
          end
        end else if (tmo_expired) begin
          err_next   = 1'b1;
          buf_next   = '0;
          state_next = RESP;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      L2_REQ: begin
        tmo_next   = '0;
        state_next = L2_WAIT;
      end
      L2_WAIT: begin
        if (l2_resp_valid_i) begin
          buf_next   = l2_resp_data_i;
          state_next = RESP;
        end else if (tmo_expired) begin
          err_next   = 1'b1;
          buf_next   = '0;
          state_next = RESP;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      RESP: begin
        beat_next  = '0;
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    brom_byte_addr      = 64'(addr_next) * LINE_BYTES + 64'(beat_next) * BEAT_BYTES;
    busy_next           = (state_next != IDLE);
    brom_req_valid_next = (state_next == BROM_REQ);
    brom_req_addr_next  = brom_req_valid_next ? BROM_ADDR_W'(brom_byte_addr) : '0;
    l2_req_valid_next   = (state_next == L2_REQ);
    l2_req_addr_next    = l2_req_valid_next ? addr_next : '0;
    resp_valid_next     = (state_next == RESP);
    resp_error_next     = resp_valid_next && err_next;
    resp_data_next      = resp_valid_next ? buf_next : ic_resp_data_o;
  end

  // State, datapath and output registers; reset abandons any transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg          <= IDLE;
      addr_reg           <= '0;
      beat_reg           <= '0;
      tmo_reg            <= '0;
      buf_reg            <= '0;
      err_reg            <= 1'b0;
      ic_resp_valid_o    <= 1'b0;
      ic_resp_data_o     <= '0;
      ic_resp_error_o    <= 1'b0;
      busy_o             <= 1'b0;
      brom_req_valid_o   <= 1'b0;
      brom_req_address_o <= '0;
      l2_req_valid_o     <= 1'b0;
      l2_req_addr_o      <= '0;
    end else begin
      state_reg          <= state_next;
      addr_reg           <= addr_next;
      beat_reg           <= beat_next;
      tmo_reg            <= tmo_next;
      buf_reg            <= buf_next;
      err_reg            <= err_next;
      ic_resp_valid_o    <= resp_valid_next;
      ic_resp_data_o     <= resp_data_next;
      ic_resp_error_o    <= resp_error_next;
      busy_o             <= busy_next;
      brom_req_valid_o   <= brom_req_valid_next;
      brom_req_address_o <= brom_req_addr_next;
      l2_req_valid_o     <= l2_req_valid_next;
      l2_req_addr_o      <= l2_req_addr_next;
    end
  end

endmodule

// File: tb/tb_icache_refill_router.sv
// Directed testbench for icache_refill_router: instance u_dut uses the default
// region with an 8-cycle timeout, u_dut_b moves the bootrom base to line 0x10.
module tb_icache_refill_router;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         req_valid = 1'b0;
  logic [25:0]  req_addr = '0;
  logic         resp_valid;
  logic [255:0] resp_data;
  logic         resp_error;
  logic         busy;
  logic         brom_req_valid;
  logic [23:0]  brom_req_addr;
  logic         brom_resp_valid = 1'b0;
  logic [127:0] brom_resp_data = '0;
  logic         l2_req_valid;
  logic [25:0]  l2_req_addr;
  logic         l2_resp_valid = 1'b0;
  logic [255:0] l2_resp_data = '0;

  logic         b_req_valid = 1'b0;
  logic [25:0]  b_req_addr = '0;
  logic         b_resp_valid;
  logic [255:0] b_resp_data;
  logic         b_resp_error;
  logic         b_busy;
  logic         b_brom_req_valid;
  logic [23:0]  b_brom_req_addr;
  logic         b_brom_resp_valid = 1'b0;
  logic [127:0] b_brom_resp_data = '0;
  logic         b_l2_req_valid;
  logic [25:0]  b_l2_req_addr;
  logic         b_l2_resp_valid = 1'b0;
  logic [255:0] b_l2_resp_data = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  icache_refill_router #(.TIMEOUT_CYC(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_valid_i(req_valid), .ic_req_addr_i(req_addr),
    .ic_resp_valid_o(resp_valid), .ic_resp_data_o(resp_data),
    .ic_resp_error_o(resp_error), .busy_o(busy),
    .brom_req_valid_o(brom_req_valid), .brom_req_address_o(brom_req_addr),
    .brom_resp_valid_i(brom_resp_valid), .brom_resp_data_i(brom_resp_data),
    .l2_req_valid_o(l2_req_valid), .l2_req_addr_o(l2_req_addr),
    .l2_resp_valid_i(l2_resp_valid), .l2_resp_data_i(l2_resp_data)
  );

  icache_refill_router #(.BROM_BASE_LINE(16), .TIMEOUT_CYC(8)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .ic_req_valid_i(b_req_valid), .ic_req_addr_i(b_req_addr),
    .ic_resp_valid_o(b_resp_valid), .ic_resp_data_o(b_resp_data),
    .ic_resp_error_o(b_resp_error), .busy_o(b_busy),
    .brom_req_valid_o(b_brom_req_valid), .brom_req_address_o(b_brom_req_addr),
    .brom_resp_valid_i(b_brom_resp_valid), .brom_resp_data_i(b_brom_resp_data),
    .l2_req_valid_o(b_l2_req_valid), .l2_req_addr_o(b_l2_req_addr),
    .l2_resp_valid_i(b_l2_resp_valid), .l2_resp_data_i(b_l2_resp_data)
  );

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a bootrom beat request on u_dut, then answer it one
  // cycle later, when the DUT is waiting for the beat.
  task automatic serve_brom(input logic [127:0] d, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (brom_req_valid) seen = 1'b1;
      else tick();
    end
    if (seen) begin
      tick();
      brom_resp_valid = 1'b1;
      brom_resp_data  = d;
      tick();
      brom_resp_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for a response pulse on u_dut; cyc counts elapsed cycles.
  task automatic wait_resp(output bit seen, output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    seen = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({resp_valid, resp_error, busy, brom_req_valid, l2_req_valid, brom_req_addr, l2_req_addr} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%h exp=0", {resp_valid, resp_error, busy, brom_req_valid, l2_req_valid, brom_req_addr, l2_req_addr});
    end
    total++;
    if (resp_data !== 256'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", resp_data);
    end
    #2 rst = 1'b0;
    tick();
    $display("txn reset released");
  endtask

  task automatic test_l2_path();
    logic [255:0] exp;
    exp = {32{8'hA5}};
    req_valid = 1'b1;
    req_addr  = 26'h000100;
    tick();                                // edge T sampled the request
    req_valid = 1'b0;
    total++;
    if (l2_req_valid !== 1'b1 || l2_req_addr !== 26'h000100 || brom_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL l2_req got v=%b a=%h bv=%b exp v=1 a=000100 bv=0", l2_req_valid, l2_req_addr, brom_req_valid);
    end
    tick();
    total++;
    if (l2_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL l2_req_pulse got=%b exp=0", l2_req_valid);
    end
    tick();
    tick();
    tick();
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL l2_wait got rv=%b busy=%b exp rv=0 busy=1", resp_valid, busy);
    end
    l2_resp_valid = 1'b1;
    l2_resp_data  = exp;
    tick();                                // edge T+5 samples the response
    l2_resp_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== exp || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL l2_resp got v=%b e=%b d=%h exp v=1 e=0 d=%h", resp_valid, resp_error, resp_data, exp);
    end
    tick();
    total++;
    if (resp_valid !== 1'b0 || resp_data !== exp || busy !== 1'b0) begin
      bad++;
      $display("FAIL l2_hold got v=%b busy=%b d=%h exp v=0 busy=0 d=%h", resp_valid, busy, resp_data, exp);
    end
    $display("txn l2 addr=000100 data=%h err=%b", resp_data, resp_error);
  endtask

  task automatic test_brom_path();
    logic [255:0] exp;
    int pulses;
    exp = {{16{8'h22}}, {16{8'h11}}};
    req_valid = 1'b1;
    req_addr  = 26'h08;
    tick();
    req_valid = 1'b0;
    total++;
    if (brom_req_valid !== 1'b1 || brom_req_addr !== 24'h000100 || l2_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL brom_beat0 got v=%b a=%h l2v=%b exp v=1 a=000100 l2v=0", brom_req_valid, brom_req_addr, l2_req_valid);
    end
    tick();
    total++;
    if (brom_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL brom_pulse got=%b exp=0", brom_req_valid);
    end
    brom_resp_valid = 1'b1;
    brom_resp_data  = {16{8'h11}};
    tick();
    brom_resp_valid = 1'b0;
    total++;
    if (brom_req_valid !== 1'b1 || brom_req_addr !== 24'h000110 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL brom_beat1 got v=%b a=%h rv=%b exp v=1 a=000110 rv=0", brom_req_valid, brom_req_addr, resp_valid);
    end
    tick();
    brom_resp_valid = 1'b1;
    brom_resp_data  = {16{8'h22}};
    tick();
    brom_resp_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== exp || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL brom_line got v=%b e=%b d=%h exp v=1 e=0 d=%h", resp_valid, resp_error, resp_data, exp);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL brom_one_pulse extra pulses got=%0d exp=0", pulses);
    end
    $display("txn brom addr=08 data=%h err=%b", resp_data, resp_error);
  endtask

  task automatic test_boundary();
    logic [255:0] exp;
    bit s0, s1, sr;
    int cyc;
    // last bootrom line
    exp = {{16{8'h3B}}, {16{8'h3A}}};
    req_valid = 1'b1;
    req_addr  = 26'h3F;
    tick();
    req_valid = 1'b0;
    total++;
    if (brom_req_valid !== 1'b1 || brom_req_addr !== 24'h0007E0 || l2_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL bound_3f got v=%b a=%h l2v=%b exp v=1 a=0007e0 l2v=0", brom_req_valid, brom_req_addr, l2_req_valid);
    end
    serve_brom({16{8'h3A}}, s0);
    serve_brom({16{8'h3B}}, s1);
    wait_resp(sr, cyc);
    total++;
    if (!(s0 && s1 && sr) || resp_data !== exp || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL bound_3f_line got seen=%b%b%b d=%h exp seen=111 d=%h", s0, s1, sr, resp_data, exp);
    end
    $display("txn brom addr=3f data=%h err=%b", resp_data, resp_error);
    tick();
    // first line past the bootrom region
    exp = {32{8'h40}};
    req_valid = 1'b1;
    req_addr  = 26'h40;
    tick();
    req_valid = 1'b0;
    total++;
    if (l2_req_valid !== 1'b1 || l2_req_addr !== 26'h40 || brom_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL bound_40 got l2v=%b a=%h bv=%b exp l2v=1 a=40 bv=0", l2_req_valid, l2_req_addr, brom_req_valid);
    end
    tick();
    l2_resp_valid = 1'b1;
    l2_resp_data  = exp;
    tick();
    l2_resp_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== exp) begin
      bad++;
      $display("FAIL bound_40_line got v=%b d=%h exp v=1 d=%h", resp_valid, resp_data, exp);
    end
    $display("txn l2 addr=40 data=%h err=%b", resp_data, resp_error);
    tick();
    // shifted base: 0x0F below the region goes to L2
    exp = {32{8'h0F}};
    b_req_valid = 1'b1;
    b_req_addr  = 26'h0F;
    tick();
    b_req_valid = 1'b0;
    total++;
    if (b_l2_req_valid !== 1'b1 || b_brom_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL base10_0f got l2v=%b bv=%b exp l2v=1 bv=0", b_l2_req_valid, b_brom_req_valid);
    end
    tick();
    b_l2_resp_valid = 1'b1;
    b_l2_resp_data  = exp;
    tick();
    b_l2_resp_valid = 1'b0;
    total++;
    if (b_resp_valid !== 1'b1 || b_resp_data !== exp || b_resp_error !== 1'b0) begin
      bad++;
      $display("FAIL base10_0f_line got v=%b e=%b d=%h exp v=1 e=0 d=%h", b_resp_valid, b_resp_error, b_resp_data, exp);
    end
    $display("txn b l2 addr=0f data=%h err=%b", b_resp_data, b_resp_error);
    tick();
    // shifted base: 0x10 is the first bootrom line; left unanswered to time out
    b_req_valid = 1'b1;
    b_req_addr  = 26'h10;
    tick();
    b_req_valid = 1'b0;
    total++;
    if (b_brom_req_valid !== 1'b1 || b_brom_req_addr !== 24'h000200 || b_l2_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL base10_10 got v=%b a=%h l2v=%b exp v=1 a=000200 l2v=0", b_brom_req_valid, b_brom_req_addr, b_l2_req_valid);
    end
    cyc = 0;
    while (!b_resp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    total++;
    if (b_resp_valid !== 1'b1 || b_resp_error !== 1'b1 || b_resp_data !== 256'd0) begin
      bad++;
      $display("FAIL base10_10_tmo got v=%b e=%b d=%h exp v=1 e=1 d=0", b_resp_valid, b_resp_error, b_resp_data);
    end
    $display("txn b brom addr=10 timeout err=%b after %0d cycles", b_resp_error, cyc);
    tick();
  endtask

  task automatic test_busy_stray();
    logic [255:0] exp;
    int l2_pulses, brom_pulses;
    exp = {32{8'h5A}};
    req_valid = 1'b1;
    req_addr  = 26'h200;
    tick();
    req_valid = 1'b0;
    l2_pulses = l2_req_valid ? 1 : 0;
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_wait got=%b exp=1", busy);
    end
    req_valid       = 1'b1;
    req_addr        = 26'h300;
    brom_resp_valid = 1'b1;
    brom_resp_data  = {16{8'hFF}};
    tick();
    req_valid       = 1'b0;
    brom_resp_valid = 1'b0;
    brom_pulses     = 0;
    for (int i = 0; i < 3; i++) begin
      if (l2_req_valid) l2_pulses++;
      if (brom_req_valid) brom_pulses++;
      tick();
    end
    total++;
    if (l2_pulses !== 1 || brom_pulses !== 0) begin
      bad++;
      $display("FAIL busy_drop got l2=%0d brom=%0d exp l2=1 brom=0", l2_pulses, brom_pulses);
    end
    l2_resp_valid = 1'b1;
    l2_resp_data  = exp;
    tick();
    l2_resp_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_data !== exp || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL stray_brom got v=%b e=%b d=%h exp v=1 e=0 d=%h", resp_valid, resp_error, resp_data, exp);
    end
    $display("txn l2 addr=200 data=%h err=%b", resp_data, resp_error);
    tick();
    total++;
    if (busy !== 1'b0 || l2_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_idle got busy=%b l2v=%b exp 0 0", busy, l2_req_valid);
    end
  endtask

  task automatic test_timeout();
    logic [255:0] exp;
    bit sr;
    int cyc, late;
    req_valid = 1'b1;
    req_addr  = 26'h123;
    tick();
    req_valid = 1'b0;
    total++;
    if (l2_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL tmo_req got=%b exp=1", l2_req_valid);
    end
    wait_resp(sr, cyc);
    total++;
    if (!sr || cyc !== 9) begin
      bad++;
      $display("FAIL tmo_latency got seen=%b cyc=%0d exp seen=1 cyc=9", sr, cyc);
    end
    total++;
    if (resp_error !== 1'b1 || resp_data !== 256'd0) begin
      bad++;
      $display("FAIL tmo_err got e=%b d=%h exp e=1 d=0", resp_error, resp_data);
    end
    $display("txn l2 addr=123 timeout err=%b after %0d cycles", resp_error, cyc);
    tick();
    l2_resp_valid = 1'b1;
    l2_resp_data  = {32{8'h77}};
    tick();
    l2_resp_valid = 1'b0;
    late = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid || busy) late++;
      tick();
    end
    total++;
    if (late !== 0 || resp_data !== 256'd0) begin
      bad++;
      $display("FAIL tmo_late got activity=%0d d=%h exp 0 d=0", late, resp_data);
    end
    // response on the last wait cycle wins over expiry
    exp = {32{8'hC3}};
    req_valid = 1'b1;
    req_addr  = 26'h124;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL tmo_early got=%b exp=0", resp_valid);
    end
    l2_resp_valid = 1'b1;
    l2_resp_data  = exp;
    tick();
    l2_resp_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_data !== exp) begin
      bad++;
      $display("FAIL tmo_coincide got v=%b e=%b d=%h exp v=1 e=0 d=%h", resp_valid, resp_error, resp_data, exp);
    end
    $display("txn l2 addr=124 data=%h err=%b", resp_data, resp_error);
    tick();
  endtask

  task automatic test_async_reset();
    logic [255:0] exp;
    bit s0, s1, sr;
    int cyc, act;
    req_valid = 1'b1;
    req_addr  = 26'h01;
    tick();
    req_valid = 1'b0;
    tick();                                // now in BROM_WAIT
    #2 rst = 1'b1;
    #1;
    total++;
    if ({resp_valid, resp_error, busy, brom_req_valid, l2_req_valid, brom_req_addr, l2_req_addr} !== '0 || resp_data !== 256'd0) begin
      bad++;
      $display("FAIL async_rst got ctrl=%h d=%h exp 0", {resp_valid, resp_error, busy, brom_req_valid, l2_req_valid}, resp_data);
    end
    #1 rst = 1'b0;
    tick();
    brom_resp_valid = 1'b1;
    brom_resp_data  = {16{8'hEE}};
    tick();
    brom_resp_valid = 1'b0;
    act = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid || brom_req_valid || busy) act++;
      tick();
    end
    total++;
    if (act !== 0) begin
      bad++;
      $display("FAIL async_late got activity=%0d exp=0", act);
    end
    exp = {{16{8'h44}}, {16{8'h33}}};
    req_valid = 1'b1;
    req_addr  = 26'h02;
    tick();
    req_valid = 1'b0;
    total++;
    if (brom_req_valid !== 1'b1 || brom_req_addr !== 24'h000040) begin
      bad++;
      $display("FAIL async_next_req got v=%b a=%h exp v=1 a=000040", brom_req_valid, brom_req_addr);
    end
    serve_brom({16{8'h33}}, s0);
    serve_brom({16{8'h44}}, s1);
    wait_resp(sr, cyc);
    total++;
    if (!(s0 && s1 && sr) || resp_data !== exp || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL async_next_line got seen=%b%b%b d=%h exp seen=111 d=%h", s0, s1, sr, resp_data, exp);
    end
    $display("txn brom addr=02 data=%h err=%b", resp_data, resp_error);
    tick();
  endtask

  initial begin
    test_reset();
    test_l2_path();
    test_brom_path();
    test_boundary();
    test_busy_stray();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_refill_router.md
Name: icache_refill_router

Overview:
- Sits between the core tile's instruction-cache refill port and the two instruction backing stores: the behavioural bootrom and the L2 model.
- Decodes each refill line address to either the bootrom region or L2.
- For bootrom lines, issues BROM_DATA_W-wide beat requests and assembles them into one LINE_SIZE line.
- Returns exactly one registered line response per accepted request, with a timeout-driven error path.

Parameters:
- LINE_SIZE, 256, refill line width in bits; line byte size is LINE_SIZE/8.
- ADDR_W, 26, line-address width.
- BROM_DATA_W, 128, bootrom response width; LINE_SIZE must be an integer multiple of it (NBEATS = LINE_SIZE/BROM_DATA_W).
- BROM_ADDR_W, 24, bootrom byte-address width.
- BROM_BASE_LINE, 0, first line address routed to bootrom.
- BROM_LINES, 64, number of lines routed to bootrom.
- TIMEOUT_CYC, 1024, max wait cycles per beat or L2 request; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous assert, active-high
- ic_req_valid_i  in  1  refill request pulse
- ic_req_addr_i  in  ADDR_W  refill line address
- ic_resp_valid_o  out  1  one-cycle response pulse
- ic_resp_data_o  out  LINE_SIZE  refill line
- ic_resp_error_o  out  1  response is a timeout error
- busy_o  out  1  high in every state except IDLE
- brom_req_valid_o  out  1  bootrom beat request pulse
- brom_req_address_o  out  BROM_ADDR_W  bootrom beat byte address
- brom_resp_valid_i  in  1  bootrom beat valid
- brom_resp_data_i  in  BROM_DATA_W  bootrom beat data
- l2_req_valid_o  out  1  L2 request pulse
- l2_req_addr_o  out  ADDR_W  L2 line address
- l2_resp_valid_i  in  1  L2 line valid
- l2_resp_data_i  in  LINE_SIZE  L2 line data

Behaviour:
- Reset: state IDLE; beat index 0; timeout counter 0; line buffer 0. All outputs are 0, including ic_resp_data_o. Reset mid-transaction abandons it; any responses arriving afterwards are ignored.
- All outputs are registered.
- States: IDLE, BROM_REQ, BROM_WAIT, L2_REQ, L2_WAIT, RESP.
- IDLE:
  - If ic_req_valid_i is high at edge T, latch the address.
  - Route to BROM_REQ when BROM_BASE_LINE <= addr < BROM_BASE_LINE+BROM_LINES, using unsigned compare with no wrap; otherwise route to L2_REQ.
  - ic_req_valid_i in any other state is dropped silently. busy_o tells the requester to hold off.
- L2_REQ: l2_req_valid_o=1 and l2_req_addr_o=latched addr for exactly one cycle (cycle T+1), then go to L2_WAIT.
- L2_WAIT: on l2_resp_valid_i, capture l2_resp_data_i and go to RESP. Minimum latency: response at T+2 gives ic_resp_valid_o at T+3.
- BROM_REQ:
  - brom_req_valid_o=1 for one cycle.
  - brom_req_address_o = (addr*(LINE_SIZE/8) + beat*(BROM_DATA_W/8)), truncated to BROM_ADDR_W.
  - Then go to BROM_WAIT.
- BROM_WAIT:
  - On brom_resp_valid_i, write data into buffer bits [beat*BROM_DATA_W +: BROM_DATA_W]; beat 0 is the least significant.
  - If beat==NBEATS-1, go to RESP; otherwise beat++ and go to BROM_REQ.
  - Beats are strictly serialised: one outstanding request at a time.
- RESP:
  - ic_resp_valid_o=1 for one cycle, ic_resp_data_o=buffer, ic_resp_error_o=error flag.
  - Next state IDLE; clear beat and error flag.
  - ic_resp_data_o holds its value until the next RESP. ic_resp_valid_o and ic_resp_error_o return to 0.
- Stray responses: brom_resp_valid_i outside BROM_WAIT and l2_resp_valid_i outside L2_WAIT are ignored. They are never merged into a later line.
- Timeout:
  - Counter clears on entry to BROM_WAIT or L2_WAIT and increments each cycle spent in a wait state.
  - When counter==TIMEOUT_CYC-1 with no response that cycle: set the error flag, clear the buffer to 0, and go to RESP.
  - If the response and expiry coincide, the response wins and there is no error.
  - After a timeout, a late response is treated as stray.
- Counter width is clog2(TIMEOUT_CYC+1), minimum 1.

Test Plan:
- L2 path: request addr 0x000100 at T; l2_resp_valid_i at T+5 with data 0xA5..A5 → l2_req_valid_o pulse at T+1 with addr 0x000100; ic_resp_valid_o at T+6 with data 0xA5..A5, error 0.
- Bootrom path (defaults): request addr 0x08 → brom_req_address_o 0x000100, then 0x000110. Beats 0x1111..11 and 0x2222..22 → ic_resp_data_o = {0x2222..22, 0x1111..11}, one pulse.
- Region boundary: addr 0x3F goes to bootrom; addr 0x40 goes to L2 with no bootrom request; BROM_BASE_LINE=0x10 with addr 0x0F goes to L2.
- Busy drop and strays: second ic_req_valid_i while in L2_WAIT produces no second l2_req. brom_resp_valid_i while in L2_WAIT leaves ic_resp_data_o equal to the L2 data.
- Timeout (TIMEOUT_CYC=8): no L2 response → ic_resp_valid_o=1, error=1, data=0 exactly 9 cycles after the l2_req pulse. A response landing on the 8th wait cycle returns its data with error 0.
- Async reset asserted mid-BROM_WAIT between edges → outputs 0 immediately. Late brom_resp_valid_i after release → no ic_resp_valid_o; next request completes normally.
